// File: rtl/traffic_sequencer.sv
// ============================================================================
// Module   : traffic_sequencer
// Brief    : Tick-paced traffic-light step sequencer with night flashing mode
//            and optional pedestrian demand (macro PED_REQUEST_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_sequencer #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       night,
    input  logic       ped_btn,
    output logic [4:0] state,
    output logic       tick,
    output logic       ped_wait
);

    localparam int unsigned     c_CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TICK_DIV - 1);

    localparam logic [4:0] c_ST_RESTART    = 5'd0;
    localparam logic [4:0] c_ST_CAR_LAST   = 5'd5;
    localparam logic [4:0] c_ST_CAR_YELLOW = 5'd6;
    localparam logic [4:0] c_ST_PED_GREEN  = 5'd7;
    localparam logic [4:0] c_ST_PED_LAST   = 5'd15;
    localparam logic [4:0] c_ST_NIGHT_ON   = 5'd16;
    localparam logic [4:0] c_ST_NIGHT_OFF  = 5'd17;

    logic [c_CW-1:0] cnt_q, cnt_d;
    logic [4:0]      state_q, state_d, state_nxt;
    logic            tick_q, tick_d;
    logic            ped_wait_q, ped_wait_d;

    always_comb begin
        cnt_d  = (cnt_q == c_LAST) ? '0 : cnt_q + c_CW'(1);
        tick_d = (cnt_d == c_LAST);
    end

    // Step function applied only on tick edges; ped phases 7..14 ignore night.
    always_comb begin
        state_nxt = c_ST_RESTART;
        if (state_q == c_ST_NIGHT_ON) begin
            state_nxt = night ? c_ST_NIGHT_OFF : c_ST_RESTART;
        end else if (state_q == c_ST_NIGHT_OFF) begin
            state_nxt = night ? c_ST_NIGHT_ON : c_ST_RESTART;
        end else if (state_q > c_ST_NIGHT_OFF) begin
            state_nxt = c_ST_RESTART;
        end else if (night && ((state_q <= c_ST_CAR_YELLOW) || (state_q == c_ST_PED_LAST))) begin
            state_nxt = c_ST_NIGHT_ON;
        end else if (state_q == c_ST_PED_LAST) begin
            state_nxt = c_ST_RESTART;
`ifdef PED_REQUEST_EN
        end else if ((state_q == c_ST_CAR_LAST) && !ped_wait_q) begin
            state_nxt = c_ST_CAR_LAST;
`endif
        end else begin
            state_nxt = state_q + 5'd1;
        end
        state_d = tick_q ? state_nxt : state_q;
    end

`ifdef PED_REQUEST_EN
    // Entering the crossing serves any pending press, including one this edge.
    always_comb begin
        ped_wait_d = ped_wait_q;
        if (tick_q && (state_nxt == c_ST_PED_GREEN)) begin
            ped_wait_d = 1'b0;
        end else if (ped_btn) begin
            ped_wait_d = 1'b1;
        end
    end
`else
    logic w_unused_ped_btn;
    assign w_unused_ped_btn = ped_btn;

    always_comb begin
        ped_wait_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            state_q    <= c_ST_RESTART;
            tick_q     <= 1'b0;
            ped_wait_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            tick_q     <= tick_d;
            ped_wait_q <= ped_wait_d;
        end
    end

    assign state    = state_q;
    assign tick     = tick_q;
    assign ped_wait = ped_wait_q;

endmodule

`default_nettype wire
